// File: rtl/writeback_arbiter_pkg.sv
// Shared types and reset values for the write-back arbiter.
// The optional WB_BYPASS_EN feature lives in writeback_arbiter.sv; nothing here depends on it.
package writeback_arbiter_pkg;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_type;

  typedef struct packed {
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
  } writeback_in_type;

  typedef struct packed {
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        alu_ready;
    logic        lsu_ready;
  } writeback_out_type;

  localparam logic        WREN_RST  = 1'b0;
  localparam logic [4:0]  WADDR_RST = 5'd0;
  localparam logic [31:0] WDATA_RST = 32'd0;

  function automatic logic is_x0(input logic [4:0] addr);
    return addr == 5'd0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO buffering LSU write-back entries; DEPTH must be a power of two.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [4:0]               push_waddr_i,
  input  logic [31:0]              push_wdata_i,
  input  logic                     pop_i,
  output logic [4:0]               head_waddr_o,
  output logic [31:0]              head_wdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  wb_entry_type     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i && (count_q != FULL_COUNT);
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{waddr: push_waddr_i, wdata: push_wdata_i};
  end

  assign head_waddr_o = mem_q[rd_ptr_q].waddr;
  assign head_wdata_o = mem_q[rd_ptr_q].wdata;
  assign count_o      = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU (priority) and queued LSU results onto the register-file write port.
// Define WB_BYPASS_EN to add the combinational read-after-write bypass ports.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_waddr,
  input  logic [31:0]                   alu_wdata,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_waddr,
  input  logic [31:0]                   lsu_wdata,
`ifdef WB_BYPASS_EN
  input  logic [4:0]                    raddr1,
  input  logic [4:0]                    raddr2,
  input  logic [31:0]                   rdata1_in,
  input  logic [31:0]                   rdata2_in,
  output logic [31:0]                   rdata1,
  output logic [31:0]                   rdata2,
`endif
  output logic                          wren,
  output logic [4:0]                    waddr,
  output logic [31:0]                   wdata,
  output logic [$clog2(QUEUE_DEPTH):0]  q_count
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [SW-1:0]    LIMIT      = SW'(STARVE_LIMIT);

  writeback_in_type  wb_in;
  writeback_out_type wb_out;

  logic [CNT_W-1:0] count;
  logic [4:0]       head_waddr;
  logic [31:0]      head_wdata;
  logic             force_drain, alu_xfer, lsu_push, pop;
  logic [SW-1:0]    starve_q, starve_d;
  logic             sel_wr;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  logic             wren_q, wren_d;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;

  assign wb_in.alu_valid = alu_valid;
  assign wb_in.alu_waddr = alu_waddr;
  assign wb_in.alu_wdata = alu_wdata;
  assign wb_in.lsu_valid = lsu_valid;
  assign wb_in.lsu_waddr = lsu_waddr;
  assign wb_in.lsu_wdata = lsu_wdata;

  // Readiness depends only on registered state, so no combinational ready path exists.
  assign force_drain = (starve_q == LIMIT) && (count != '0);
  assign alu_xfer    = wb_in.alu_valid && !force_drain;
  assign lsu_push    = wb_in.lsu_valid && wb_out.lsu_ready && !is_x0(wb_in.lsu_waddr);

  wb_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (lsu_push),
    .push_waddr_i (wb_in.lsu_waddr),
    .push_wdata_i (wb_in.lsu_wdata),
    .pop_i        (pop),
    .head_waddr_o (head_waddr),
    .head_wdata_o (head_wdata),
    .count_o      (count)
  );

  always_comb begin
    pop      = 1'b0;
    starve_d = '0;
    sel_wr   = 1'b0;
    sel_addr = waddr_q;
    sel_data = wdata_q;
    if (force_drain) begin
      pop      = 1'b1;
      sel_wr   = 1'b1;
      sel_addr = head_waddr;
      sel_data = head_wdata;
    end else if (alu_xfer) begin
      sel_wr   = 1'b1;
      sel_addr = wb_in.alu_waddr;
      sel_data = wb_in.alu_wdata;
      if (count != '0) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
    end else if (count != '0) begin
      pop      = 1'b1;
      sel_wr   = 1'b1;
      sel_addr = head_waddr;
      sel_data = head_wdata;
    end
    wren_d = sel_wr && !is_x0(sel_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q   <= WREN_RST;
      waddr_q  <= WADDR_RST;
      wdata_q  <= WDATA_RST;
      starve_q <= '0;
    end else begin
      wren_q   <= wren_d;
      waddr_q  <= sel_addr;
      wdata_q  <= sel_data;
      starve_q <= starve_d;
    end
  end

  assign wb_out.wren      = wren_q;
  assign wb_out.waddr     = waddr_q;
  assign wb_out.wdata     = wdata_q;
  assign wb_out.alu_ready = !force_drain;
  assign wb_out.lsu_ready = (count != FULL_COUNT);

  assign wren      = wb_out.wren;
  assign waddr     = wb_out.waddr;
  assign wdata     = wb_out.wdata;
  assign alu_ready = wb_out.alu_ready;
  assign lsu_ready = wb_out.lsu_ready;
  assign q_count   = count;

`ifdef WB_BYPASS_EN
  assign rdata1 = (wren_q && (waddr_q == raddr1) && !is_x0(waddr_q)) ? wdata_q : rdata1_in;
  assign rdata2 = (wren_q && (waddr_q == raddr2) && !is_x0(waddr_q)) ? wdata_q : rdata2_in;
`endif

endmodule
